// File: rtl/pattern_detect_sched.sv
// rtl/pattern_detect_sched.sv - round-robin time-shared programmable serial pattern detector
//
// Purpose: one Moore-style pattern detector (up to PMAX bits) shared by N serial
//   bit streams. A round-robin arbiter grants one bit per cycle, and each channel
//   keeps its own history, so the streams stay independent.
//   Pattern, length and overlap mode can be reprogrammed at runtime.
// Optional feature macro: PDS_CNT_EN (per-channel saturating match counters).
// Ports:
//   clk            clock, all state on rising edge
//   reset          asynchronous, active-high
//   cfg_load_i     pulse: latch cfg_* and clear all channel contexts
//   cfg_pattern_i  pattern, bits [len-1:0] used, bit len-1 received first
//   cfg_len_i      pattern length, 0 -> 1, >PMAX -> PMAX
//   cfg_overlap_i  1 = overlapping detection, 0 = non-overlapping
//   in_valid_i     per-channel bit available
//   in_bit_i       per-channel serial data bit
//   in_ready_o     one-hot grant (combinational), transfer = valid & ready
//   match_o        registered one-cycle pulse on pattern completion
//   match_ch_o     channel of the last match, held between pulses
//   match_cnt_o    per-channel match counts, ch0 in LSBs (PDS_CNT_EN only)
module pattern_detect_sched #(
  parameter int              N       = 4,
  parameter int              PMAX    = 8,
  parameter int              CNT_W   = 8,
  parameter logic [PMAX-1:0] DEF_PAT = PMAX'(9),
  parameter int              DEF_LEN = 4,
  parameter logic            DEF_OVL = 1'b0,
  localparam int             LEN_W   = $clog2(PMAX + 1),
  localparam int             CH_W    = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load_i,
  input  logic [PMAX-1:0]    cfg_pattern_i,
  input  logic [LEN_W-1:0]   cfg_len_i,
  input  logic               cfg_overlap_i,
  input  logic [N-1:0]       in_valid_i,
  input  logic [N-1:0]       in_bit_i,
  output logic [N-1:0]       in_ready_o,
  output logic               match_o,
`ifdef PDS_CNT_EN
  output logic [N*CNT_W-1:0] match_cnt_o,
`endif
  output logic [CH_W-1:0]    match_ch_o
);

  logic [PMAX-1:0]  pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  logic [PMAX-1:0]  hist_q [N];
  logic [LEN_W-1:0] seen_q [N];
  logic [CH_W-1:0]  rr_q;
  logic             match_q;
  logic [CH_W-1:0]  match_ch_q;

  logic             grant_vld;
  logic [CH_W-1:0]  grant_ch;
  logic [CH_W-1:0]  cand;
  logic             xfer;
  logic [PMAX-1:0]  hist_d;
  logic [LEN_W-1:0] seen_d;
  logic [PMAX-1:0]  len_mask;
  logic [LEN_W-1:0] cfg_len_eff;
  logic [CH_W-1:0]  rr_d;
  logic             hit;

  // First valid channel at or above rr_q, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = CH_W'((int'(rr_q) + k) % N);
      if (!grant_vld && in_valid_i[cand]) begin
        grant_vld = 1'b1;
        grant_ch  = cand;
      end
    end
  end

  // No transfer during reset or on a configuration load cycle.
  assign xfer = grant_vld & ~cfg_load_i & ~reset;

  always_comb begin
    in_ready_o = '0;
    if (xfer) in_ready_o[grant_ch] = 1'b1;
  end

  assign hist_d = {hist_q[grant_ch][PMAX-2:0], in_bit_i[grant_ch]};
  assign seen_d = (seen_q[grant_ch] == LEN_W'(PMAX)) ? LEN_W'(PMAX)
                                                     : seen_q[grant_ch] + 1'b1;
  // len_q is always 1..PMAX, so the shift yields exactly len_q low ones.
  assign len_mask = ~({PMAX{1'b1}} << len_q);
  assign hit = xfer && (((hist_d ^ pat_q) & len_mask) == '0) && (seen_d >= len_q);

  assign rr_d = (grant_ch == CH_W'(N - 1)) ? '0 : grant_ch + 1'b1;

  always_comb begin
    cfg_len_eff = cfg_len_i;
    if (cfg_len_i == '0)                cfg_len_eff = LEN_W'(1);
    else if (cfg_len_i > LEN_W'(PMAX))  cfg_len_eff = LEN_W'(PMAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q      <= DEF_PAT;
      len_q      <= LEN_W'(DEF_LEN);
      ovl_q      <= DEF_OVL;
      rr_q       <= '0;
      match_q    <= 1'b0;
      match_ch_q <= '0;
      for (int i = 0; i < N; i++) begin
        hist_q[i] <= '0;
        seen_q[i] <= '0;
      end
    end else begin
      match_q <= hit;
      if (hit) match_ch_q <= grant_ch;
      if (cfg_load_i) begin
        pat_q <= cfg_pattern_i;
        len_q <= cfg_len_eff;
        ovl_q <= cfg_overlap_i;
        for (int i = 0; i < N; i++) begin
          hist_q[i] <= '0;
          seen_q[i] <= '0;
        end
      end else if (xfer) begin
        hist_q[grant_ch] <= hist_d;
        // Non-overlapping mode forgets the matched window by restarting the bit count.
        seen_q[grant_ch] <= (hit && !ovl_q) ? '0 : seen_d;
        rr_q             <= rr_d;
      end
    end
  end

  assign match_o    = match_q;
  assign match_ch_o = match_ch_q;

`ifdef PDS_CNT_EN
  logic [CNT_W-1:0] cnt_q [N];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else if (hit && (cnt_q[grant_ch] != {CNT_W{1'b1}})) begin
      cnt_q[grant_ch] <= cnt_q[grant_ch] + 1'b1;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_cnt_out
    assign match_cnt_o[gi*CNT_W +: CNT_W] = cnt_q[gi];
  end
`endif

endmodule
